// File: rtl/led_bank_pkg.sv
// Shared types and constants for the LED blinker bank.
package led_bank_pkg;

    // Per-channel operating mode.
    typedef enum logic [1:0] {
        LM_OFF   = 2'd0,
        LM_ON    = 2'd1,
        LM_BLINK = 2'd2,
        LM_PULSE = 2'd3
    } led_mode_t;

    // Prescaler divide ratio used when building for simulation.
    localparam int SIM_TICK_DIV = 100;

    // LED level a channel shows in the cycle right after it is configured.
    function automatic logic mode_led_init(input led_mode_t mode);
        logic led_v;
        case (mode)
            LM_OFF:   led_v = 1'b0;
            LM_ON:    led_v = 1'b1;
            LM_BLINK: led_v = 1'b1;
            LM_PULSE: led_v = 1'b1;
            default:  led_v = 1'b0;
        endcase
        return led_v;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode, period, tick phase, LED level and pulse-busy flag.
// A write always wins over a same-cycle tick and restarts the channel at phase 0.
module led_channel
    import led_bank_pkg::*;
#(
    parameter int PER_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tick,
    input  logic             wr,
    input  led_mode_t        mode,
    input  logic [PER_W-1:0] period,
    output logic             led,
    output logic             busy
);

    led_mode_t        mode_r;
    led_mode_t        mode_s;
    logic [PER_W-1:0] period_r;
    logic [PER_W-1:0] period_s;
    logic [PER_W-1:0] phase_r;
    logic [PER_W-1:0] phase_s;
    logic             led_r;
    logic             led_s;
    logic             busy_r;
    logic             busy_s;
    logic [PER_W-1:0] last_phase_s;
    logic             phase_end_s;

    // Last phase index of a period; a period of 0 behaves like 1, so both end at phase 0.
    always_comb begin
        last_phase_s = {PER_W{1'b0}};
        if (period_r == {PER_W{1'b0}}) begin
            last_phase_s = {PER_W{1'b0}};
        end else begin
            last_phase_s = period_r - PER_W'(1'b1);
        end
        phase_end_s = (phase_r == last_phase_s);
    end

    // Next-state logic: configuration load has priority, otherwise advance on tick.
    always_comb begin
        mode_s   = mode_r;
        period_s = period_r;
        phase_s  = phase_r;
        led_s    = led_r;
        busy_s   = busy_r;
        if (wr) begin
            mode_s   = mode;
            period_s = period;
            phase_s  = {PER_W{1'b0}};
            led_s    = mode_led_init(mode);
            busy_s   = (mode == LM_PULSE);
        end else if (tick) begin
            case (mode_r)
                LM_BLINK: begin
                    if (phase_end_s) begin
                        phase_s = {PER_W{1'b0}};
                        led_s   = ~led_r;
                    end else begin
                        phase_s = phase_r + PER_W'(1'b1);
                    end
                end
                LM_PULSE: begin
                    if (phase_end_s) begin
                        led_s  = 1'b0;
                        busy_s = 1'b0;
                        mode_s = LM_OFF;
                    end else begin
                        phase_s = phase_r + PER_W'(1'b1);
                    end
                end
                default: begin
                    // OFF and ON ignore the tick and hold their level.
                    phase_s = phase_r;
                end
            endcase
        end else begin
            phase_s = phase_r;
        end
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_r   <= LM_OFF;
            period_r <= {PER_W{1'b0}};
            phase_r  <= {PER_W{1'b0}};
            led_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            mode_r   <= mode_s;
            period_r <= period_s;
            phase_r  <= phase_s;
            led_r    <= led_s;
            busy_r   <= busy_s;
        end
    end

    assign led  = led_r;
    assign busy = busy_r;

endmodule

// File: rtl/led_blinker_bank.sv
// Bank of NB_LEDS independently configured LED channels sharing one prescaler tick.
// Out-of-range channel indices decode to no channel, so such writes are dropped.
module led_blinker_bank
    import led_bank_pkg::*;
#(
    parameter int NB_LEDS  = 8,
`ifdef SIMULATION
    parameter int TICK_DIV = SIM_TICK_DIV,
`else
    parameter int TICK_DIV = 100_000_000,
`endif
    parameter int PER_W    = 8,
    localparam int IDX_W   = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  led_mode_t          cfg_mode,
    input  logic [PER_W-1:0]   cfg_period,
    output logic               tick,
    output logic [NB_LEDS-1:0] led,
    output logic [NB_LEDS-1:0] busy
);

    localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]   cnt_r;
    logic               tick_s;
    logic [NB_LEDS-1:0] wr_s;

    // Tick is decoded straight from the counter so it lines up with the wrap.
    always_comb begin
        tick_s = (cnt_r == CNT_MAX);
    end

    // Free-running prescaler counting 0..TICK_DIV-1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    // One-hot write select for the addressed channel.
    always_comb begin
        wr_s = {NB_LEDS{1'b0}};
        for (int i = 0; i < NB_LEDS; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                wr_s[i] = 1'b1;
            end else begin
                wr_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NB_LEDS; g++) begin : g_chan
        led_channel #(
            .PER_W (PER_W)
        ) u_chan (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .tick    (tick_s),
            .wr      (wr_s[g]),
            .mode    (cfg_mode),
            .period  (cfg_period),
            .led     (led[g]),
            .busy    (busy[g])
        );
    end

    assign tick = tick_s;

endmodule

// File: tb/tb_led_blinker_bank.sv
// Self-checking bench for led_blinker_bank (NB_LEDS=6, TICK_DIV=10, PER_W=4).
// The reference model tracks, per channel, the mode last written and how many
// ticks have elapsed since that write, and derives LED/busy arithmetically.
module tb_led_blinker_bank;
    import led_bank_pkg::*;

    localparam int NL = 6;
    localparam int TD = 10;
    localparam int PW = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cfg_we;
    logic [2:0]    cfg_idx;
    led_mode_t     cfg_mode;
    logic [PW-1:0] cfg_period;
    logic          tick;
    logic [NL-1:0] led;
    logic [NL-1:0] busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int        cyc;
    led_mode_t m_mode  [NL];
    int        m_per   [NL];
    int        m_ticks [NL];

    led_blinker_bank #(
        .NB_LEDS  (NL),
        .TICK_DIV (TD),
        .PER_W    (PW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .tick       (tick),
        .led        (led),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Advance one clock: update the model for the edge, then check at the falling edge.
    task automatic cycle();
        logic          t;
        logic          exp_t;
        logic [NL-1:0] exp_led;
        logic [NL-1:0] exp_busy;
        @(posedge sys_clk);
        t = ((cyc % TD) == (TD - 1));
        if (sys_rst) begin
            cyc = 0;
            for (int c = 0; c < NL; c++) begin
                m_mode[c]  = LM_OFF;
                m_per[c]   = 1;
                m_ticks[c] = 0;
            end
        end else begin
            for (int c = 0; c < NL; c++) begin
                if (cfg_we && (int'(cfg_idx) == c)) begin
                    m_mode[c]  = cfg_mode;
                    m_per[c]   = (cfg_period == 4'd0) ? 1 : int'(cfg_period);
                    m_ticks[c] = 0;
                end else if (t) begin
                    m_ticks[c] = m_ticks[c] + 1;
                end
            end
            cyc = cyc + 1;
        end
        @(negedge sys_clk);
        exp_t = ((cyc % TD) == (TD - 1));
        for (int c = 0; c < NL; c++) begin
            case (m_mode[c])
                LM_ON:    begin exp_led[c] = 1'b1; exp_busy[c] = 1'b0; end
                LM_BLINK: begin exp_led[c] = (((m_ticks[c] / m_per[c]) % 2) == 0); exp_busy[c] = 1'b0; end
                LM_PULSE: begin exp_led[c] = (m_ticks[c] < m_per[c]); exp_busy[c] = (m_ticks[c] < m_per[c]); end
                default:  begin exp_led[c] = 1'b0; exp_busy[c] = 1'b0; end
            endcase
        end
        n_checks++;
        assert (tick === exp_t) else begin
            n_errors++;
            $error("FAIL tick cyc=%0d observed=%b expected=%b", cyc, tick, exp_t);
        end
        n_checks++;
        assert (led === exp_led) else begin
            n_errors++;
            $error("FAIL led cyc=%0d observed=%b expected=%b", cyc, led, exp_led);
        end
        n_checks++;
        assert (busy === exp_busy) else begin
            n_errors++;
            $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, exp_busy);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
        end
    endtask

    task automatic wr(input logic [2:0] idx, input led_mode_t mode, input logic [PW-1:0] per);
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_mode   = mode;
        cfg_period = per;
        cycle();
        cfg_we     = 1'b0;
    endtask

    // Spin until the current cycle is a tick cycle (bounded by the prescaler period).
    task automatic align_to_tick();
        for (int i = 0; (i < TD) && ((cyc % TD) != (TD - 1)); i++) begin
            cycle();
        end
    endtask

    initial begin
        sys_rst    = 1'b1;
        cfg_we     = 1'b0;
        cfg_idx    = 3'd0;
        cfg_mode   = LM_OFF;
        cfg_period = 4'd0;
        cyc        = 0;
        for (int c = 0; c < NL; c++) begin
            m_mode[c]  = LM_OFF;
            m_per[c]   = 1;
            m_ticks[c] = 0;
        end

        // Reset, then free-run: ticks at cycles 9, 19, 29 only.
        idle(2);
        sys_rst = 1'b0;
        idle(32);

        // BLINK period 3 on channel 0.
        wr(3'd0, LM_BLINK, 4'd3);
        idle(75);

        // PULSE period 2 on channel 2, then let later ticks pass.
        wr(3'd2, LM_PULSE, 4'd2);
        idle(40);

        // BLINK period 0 on channel 1 toggles each tick; then ON written on a tick cycle.
        wr(3'd1, LM_BLINK, 4'd0);
        idle(25);
        align_to_tick();
        wr(3'd1, LM_ON, 4'd5);
        idle(22);

        // Rewrite channel 0 on a tick cycle: the write wins and restarts it.
        align_to_tick();
        wr(3'd0, LM_BLINK, 4'd2);
        idle(45);

        // Out-of-range indices must leave every channel alone.
        wr(3'd7, LM_PULSE, 4'd1);
        idle(3);
        wr(3'd6, LM_ON, 4'd4);
        idle(20);

        // Reset in the middle of BLINK + PULSE activity.
        wr(3'd3, LM_PULSE, 4'd9);
        wr(3'd4, LM_BLINK, 4'd1);
        idle(7);
        sys_rst = 1'b1;
        cycle();
        sys_rst = 1'b0;
        idle(25);

        // Randomized traffic including occasional resets.
        for (int k = 0; k < 250; k++) begin
            idle($urandom_range(0, 12));
            if ($urandom_range(0, 39) == 0) begin
                sys_rst = 1'b1;
                idle($urandom_range(1, 2));
                sys_rst = 1'b0;
            end else begin
                wr(3'($urandom_range(0, 7)), led_mode_t'($urandom_range(0, 3)),
                   PW'($urandom_range(0, 15)));
            end
        end
        idle(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
